// File: rtl/snoop_txn_sched.sv
// snoop_txn_sched: schedules ACE snoops for NUM_MASTERS initiators and sequences the line aggregator.
// Latency: grant -> AC broadcast next cycle; CR collection -> WAIT_AGGR; verdict -> completion next cycle.
// Backpressure: AC held per target until ac_ready; completion held until cmp_ready; requests stay pending while busy.
// Ports: ACLK/ARESET; req_* (request side), ac_*/cr_* (snoop channels), crresp_vld/aggr_* (aggregator),
//        cmp_* (completion to initiator), busy (any state except IDLE).
module snoop_txn_sched #(
  parameter int NUM_MASTERS = 8,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_MASTERS-1:0]        req_vld,
  input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr,
  input  logic [NUM_MASTERS*4-1:0]      req_snoop,
  output logic [NUM_MASTERS-1:0]        req_rdy,
  output logic [NUM_MASTERS-1:0]        ac_valid,
  input  logic [NUM_MASTERS-1:0]        ac_ready,
  output logic [ADDR_W-1:0]             ac_addr,
  output logic [3:0]                    ac_snoop,
  input  logic [NUM_MASTERS-1:0]        cr_valid,
  output logic [NUM_MASTERS-1:0]        cr_ready,
  output logic [NUM_MASTERS-1:0]        crresp_vld,
  output logic                          aggr_clear,
  input  logic                          aggr_data_rdy,
  input  logic                          aggr_no_data,
  output logic [NUM_MASTERS-1:0]        cmp_valid,
  input  logic [NUM_MASTERS-1:0]        cmp_ready,
  output logic                          cmp_nodata,
  output logic                          cmp_err,
  output logic                          busy
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
  localparam logic [IDW-1:0]         LAST_ID  = IDW'(NUM_MASTERS - 1);
  localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SNOOP, WAIT_AGGR, COMPLETE, CLEAR} state_t;

  state_t                 state;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         init_id;
  logic [NUM_MASTERS-1:0] ac_done;
  logic [NUM_MASTERS-1:0] collected;
  logic [TW-1:0]          tmo_cnt;

  logic                   grant_vld;
  logic [IDW-1:0]         grant_id;
  logic [IDW-1:0]         cand;
  int                     rr_idx;
  logic [ADDR_W-1:0]      grant_addr;
  logic [3:0]             grant_snoop;
  logic [NUM_MASTERS-1:0] init_mask;
  logic [NUM_MASTERS-1:0] tgt_mask;
  logic [NUM_MASTERS-1:0] ac_done_nxt;
  logic [NUM_MASTERS-1:0] coll_nxt;

  // Round-robin search: walk from the farthest candidate back to rr_ptr so the
  // nearest pending requester (lowest offset) is the last, winning assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    cand      = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      rr_idx = (int'(rr_ptr) + k) % NUM_MASTERS;
      cand   = IDW'(rr_idx);
      if (req_vld[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    grant_addr  = '0;
    grant_snoop = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_id == IDW'(i)) begin
        grant_addr  = req_addr[i*ADDR_W +: ADDR_W];
        grant_snoop = req_snoop[i*4 +: 4];
      end
    end
  end

  assign init_mask   = ONE << init_id;
  assign tgt_mask    = ~init_mask;
  assign ac_done_nxt = ac_done | (ac_valid & ac_ready);
  // cr_ready is registered from ac_done, so a CR presented in the same cycle
  // as its own AC handshake sees cr_ready low and must be held one more cycle.
  assign coll_nxt    = collected | (cr_valid & cr_ready);
  assign busy        = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      init_id    <= '0;
      ac_done    <= '0;
      collected  <= '0;
      tmo_cnt    <= '0;
      req_rdy    <= '0;
      ac_valid   <= '0;
      ac_addr    <= '0;
      ac_snoop   <= '0;
      cr_ready   <= '0;
      crresp_vld <= '0;
      aggr_clear <= 1'b0;
      cmp_valid  <= '0;
      cmp_nodata <= 1'b0;
      cmp_err    <= 1'b0;
    end else begin
      req_rdy    <= '0;
      aggr_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            init_id    <= grant_id;
            ac_addr    <= grant_addr;
            ac_snoop   <= grant_snoop;
            req_rdy    <= ONE << grant_id;
            ac_valid   <= ~(ONE << grant_id);
            crresp_vld <= ONE << grant_id;
            ac_done    <= '0;
            collected  <= '0;
            cr_ready   <= '0;
            state      <= SNOOP;
          end
        end
        SNOOP: begin
          ac_valid   <= ac_valid & ~ac_ready;
          ac_done    <= ac_done_nxt;
          collected  <= coll_nxt;
          cr_ready   <= ac_done_nxt & ~coll_nxt;
          crresp_vld <= coll_nxt | init_mask;
          // With a single master the target mask is empty and this exits at once.
          if ((coll_nxt & tgt_mask) == tgt_mask) begin
            tmo_cnt <= '0;
            state   <= WAIT_AGGR;
          end
        end
        WAIT_AGGR: begin
          if (aggr_data_rdy) begin
            cmp_valid  <= init_mask;
            cmp_nodata <= 1'b0;
            cmp_err    <= 1'b0;
            state      <= COMPLETE;
          end else if (aggr_no_data) begin
            cmp_valid  <= init_mask;
            cmp_nodata <= 1'b1;
            cmp_err    <= 1'b0;
            state      <= COMPLETE;
          end else if (tmo_cnt == TMO_LAST) begin
            cmp_valid  <= init_mask;
            cmp_nodata <= 1'b0;
            cmp_err    <= 1'b1;
            state      <= COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        COMPLETE: begin
          if (|(cmp_ready & init_mask)) begin
            cmp_valid  <= '0;
            cmp_nodata <= 1'b0;
            cmp_err    <= 1'b0;
            aggr_clear <= 1'b1;
            collected  <= '0;
            ac_done    <= '0;
            crresp_vld <= '0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          rr_ptr <= (init_id == LAST_ID) ? '0 : init_id + IDW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_txn_sched.sv
module tb_snoop_txn_sched;
  localparam int N   = 8;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N*4-1:0]  req_snoop;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    ac_valid;
  logic [N-1:0]    ac_ready;
  logic [AW-1:0]   ac_addr;
  logic [3:0]      ac_snoop;
  logic [N-1:0]    cr_valid;
  logic [N-1:0]    cr_ready;
  logic [N-1:0]    crresp_vld;
  logic            aggr_clear;
  logic            aggr_data_rdy;
  logic            aggr_no_data;
  logic [N-1:0]    cmp_valid;
  logic [N-1:0]    cmp_ready;
  logic            cmp_nodata;
  logic            cmp_err;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  snoop_txn_sched #(.NUM_MASTERS(N), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_vld(req_vld), .req_addr(req_addr), .req_snoop(req_snoop), .req_rdy(req_rdy),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_snoop(ac_snoop),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .crresp_vld(crresp_vld),
    .aggr_clear(aggr_clear), .aggr_data_rdy(aggr_data_rdy), .aggr_no_data(aggr_no_data),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_nodata(cmp_nodata), .cmp_err(cmp_err),
    .busy(busy)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET = 1'b1; req_vld = '0; req_addr = '0; req_snoop = '0;
    ac_ready = '0; cr_valid = '0; aggr_data_rdy = 1'b0; aggr_no_data = 1'b0; cmp_ready = '0;
    tick(); tick();
    chk("rst_busy",      64'(busy),       64'h0);
    chk("rst_req_rdy",   64'(req_rdy),    64'h0);
    chk("rst_ac_valid",  64'(ac_valid),   64'h0);
    chk("rst_cr_ready",  64'(cr_ready),   64'h0);
    chk("rst_crresp",    64'(crresp_vld), 64'h0);
    chk("rst_cmp_valid", 64'(cmp_valid),  64'h0);
    chk("rst_clear",     64'(aggr_clear), 64'h0);
    chk("rst_ac_addr",   64'(ac_addr),    64'h0);

    // Basic transaction from master 2, all targets respond immediately.
    ARESET = 1'b0;
    req_addr[2*AW +: AW] = 32'h0000_1000; req_snoop[2*4 +: 4] = 4'h1;
    req_vld = 8'h04; ac_ready = 8'hFF; cr_valid = 8'hFF;
    tick();
    chk("t1_req_rdy",  64'(req_rdy),    64'h04);
    chk("t1_ac_valid", 64'(ac_valid),   64'hFB);
    chk("t1_ac_addr",  64'(ac_addr),    64'h1000);
    chk("t1_ac_snoop", 64'(ac_snoop),   64'h1);
    chk("t1_crresp0",  64'(crresp_vld), 64'h04);
    chk("t1_busy",     64'(busy),       64'h1);
    req_vld = '0;
    tick();
    chk("t1_req_rdy_pulse", 64'(req_rdy),  64'h00);
    chk("t1_ac_drop",       64'(ac_valid), 64'h00);
    chk("t1_cr_ready",      64'(cr_ready), 64'hFB);
    tick();
    chk("t1_crresp_full", 64'(crresp_vld), 64'hFF);
    chk("t1_cr_ready_off", 64'(cr_ready),  64'h00);
    chk("t1_no_cmp_yet",  64'(cmp_valid),  64'h00);
    aggr_data_rdy = 1'b1;
    tick();
    aggr_data_rdy = 1'b0;
    chk("t1_cmp_valid",  64'(cmp_valid),  64'h04);
    chk("t1_cmp_nodata", 64'(cmp_nodata), 64'h0);
    chk("t1_cmp_err",    64'(cmp_err),    64'h0);
    tick();
    chk("t1_cmp_held", 64'(cmp_valid), 64'h04);
    cmp_ready = 8'h04;
    tick();
    cmp_ready = '0;
    chk("t1_clear",      64'(aggr_clear), 64'h1);
    chk("t1_cmp_drop",   64'(cmp_valid),  64'h00);
    chk("t1_crresp_clr", 64'(crresp_vld), 64'h00);
    tick();
    chk("t1_clear_pulse", 64'(aggr_clear), 64'h0);
    chk("t1_idle",        64'(busy),       64'h0);

    // rr_ptr=3: masters 7 and 0 pending, 7 wins, then 0.
    req_addr[7*AW +: AW] = 32'h0000_7000; req_snoop[7*4 +: 4] = 4'h2;
    req_addr[0*AW +: AW] = 32'h0000_0040; req_snoop[0*4 +: 4] = 4'h3;
    req_vld = 8'h81;
    tick();
    chk("t2_grant7",    64'(req_rdy),  64'h80);
    chk("t2_ac_valid7", 64'(ac_valid), 64'h7F);
    chk("t2_ac_addr7",  64'(ac_addr),  64'h7000);
    req_vld = 8'h01;
    tick(); tick();
    chk("t2_crresp7", 64'(crresp_vld), 64'hFF);
    aggr_no_data = 1'b1;
    tick();
    aggr_no_data = 1'b0;
    chk("t2_cmp7",        64'(cmp_valid),  64'h80);
    chk("t2_nodata_only", 64'(cmp_nodata), 64'h1);
    chk("t2_err7",        64'(cmp_err),    64'h0);
    cmp_ready = 8'h80;
    tick();
    cmp_ready = '0;
    chk("t2_clear7",       64'(aggr_clear), 64'h1);
    chk("t2_nodata_clear", 64'(cmp_nodata), 64'h0);
    tick();
    chk("t2_idle_gap_busy", 64'(busy),    64'h0);
    chk("t2_idle_gap_rdy",  64'(req_rdy), 64'h00);
    tick();
    chk("t2_grant0",    64'(req_rdy),  64'h01);
    chk("t2_ac_addr0",  64'(ac_addr),  64'h40);
    chk("t2_ac_snoop0", 64'(ac_snoop), 64'h3);
    chk("t2_ac_valid0", 64'(ac_valid), 64'hFE);
    req_vld = '0;
    tick(); tick();
    aggr_data_rdy = 1'b1; aggr_no_data = 1'b1;
    tick();
    aggr_data_rdy = 1'b0; aggr_no_data = 1'b0;
    chk("t2_cmp0",         64'(cmp_valid),  64'h01);
    chk("t2_both_nodata0", 64'(cmp_nodata), 64'h0);
    cmp_ready = 8'h01;
    tick();
    cmp_ready = '0;
    tick();

    // rr_ptr=1: masters 0,1 pending -> 1. Target 5 is slow on AC and CR;
    // data_rdy held high so any early WAIT_AGGR would complete prematurely.
    req_vld = 8'h03; ac_ready = 8'hDF; cr_valid = 8'hDF; aggr_data_rdy = 1'b1;
    tick();
    chk("t3_grant1",    64'(req_rdy),  64'h02);
    chk("t3_ac_valid1", 64'(ac_valid), 64'hFD);
    req_vld = '0;
    tick();
    chk("t3_ac_held5", 64'(ac_valid),   64'h20);
    chk("t3_cr_ready", 64'(cr_ready),   64'hDD);
    chk("t3_crresp_a", 64'(crresp_vld), 64'h02);
    tick();
    chk("t3_crresp_b",  64'(crresp_vld), 64'hDF);
    chk("t3_cr_rdy_off", 64'(cr_ready),  64'h00);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_wait_ac5",   64'(ac_valid),  64'h20);
      chk("t3_no_cmp_ac",  64'(cmp_valid), 64'h00);
    end
    ac_ready = 8'hFF;
    tick();
    chk("t3_ac5_done",   64'(ac_valid),   64'h00);
    chk("t3_cr_ready5",  64'(cr_ready),   64'h20);
    chk("t3_crresp5_lo", 64'(crresp_vld), 64'hDF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_wait_cr5",  64'(crresp_vld), 64'hDF);
      chk("t3_cr_rdy5",   64'(cr_ready),   64'h20);
      chk("t3_no_cmp_cr", 64'(cmp_valid),  64'h00);
    end
    cr_valid = 8'hFF;
    tick();
    chk("t3_crresp_full", 64'(crresp_vld), 64'hFF);
    chk("t3_no_cmp_yet",  64'(cmp_valid),  64'h00);
    tick();
    chk("t3_cmp1", 64'(cmp_valid), 64'h02);
    aggr_data_rdy = 1'b0;
    cmp_ready = 8'h02;
    tick();
    cmp_ready = '0;
    tick();

    // rr_ptr=2: master 0 alone. CR on target 2 arrives with its AC handshake.
    req_vld = 8'h01; ac_ready = 8'hFB; cr_valid = 8'hFB;
    tick();
    chk("t4_grant0",    64'(req_rdy),  64'h01);
    chk("t4_ac_valid",  64'(ac_valid), 64'hFE);
    req_vld = '0;
    tick();
    chk("t4_ac_held2", 64'(ac_valid), 64'h04);
    chk("t4_cr_ready", 64'(cr_ready), 64'hFA);
    tick();
    chk("t4_crresp_a", 64'(crresp_vld), 64'hFB);
    ac_ready = 8'hFF; cr_valid = 8'hFF;
    chk("t4_same_cycle_cr_rdy", 64'(cr_ready), 64'h00);
    tick();
    chk("t4_ac2_done",    64'(ac_valid),   64'h00);
    chk("t4_cr_ready2",   64'(cr_ready),   64'h04);
    chk("t4_cr2_not_acc", 64'(crresp_vld), 64'hFB);
    tick();
    chk("t4_cr2_acc", 64'(crresp_vld), 64'hFF);
    // No aggregator verdict: WAIT_AGGR times out after 16 cycles.
    repeat (15) tick();
    chk("t4_tmo_not_yet", 64'(cmp_valid), 64'h00);
    chk("t4_tmo_busy",    64'(busy),      64'h1);
    tick();
    chk("t4_tmo_cmp",    64'(cmp_valid),  64'h01);
    chk("t4_tmo_err",    64'(cmp_err),    64'h1);
    chk("t4_tmo_nodata", 64'(cmp_nodata), 64'h0);
    cmp_ready = 8'h01;
    tick();
    cmp_ready = '0;
    chk("t4_clear",     64'(aggr_clear), 64'h1);
    chk("t4_err_clear", 64'(cmp_err),    64'h0);
    tick();

    // rr_ptr=1: grant master 3, then reset in the middle of SNOOP.
    req_vld = 8'h08; ac_ready = '0; cr_valid = '0;
    tick();
    chk("t5_grant3",    64'(req_rdy),  64'h08);
    chk("t5_ac_valid3", 64'(ac_valid), 64'hF7);
    req_vld = '0; ac_ready = 8'hFF;
    tick();
    chk("t5_cr_ready", 64'(cr_ready), 64'hF7);
    ARESET = 1'b1; aggr_data_rdy = 1'b1;
    tick();
    chk("t5_rst_ac_valid", 64'(ac_valid),   64'h00);
    chk("t5_rst_cr_ready", 64'(cr_ready),   64'h00);
    chk("t5_rst_crresp",   64'(crresp_vld), 64'h00);
    chk("t5_rst_busy",     64'(busy),       64'h0);
    chk("t5_rst_cmp",      64'(cmp_valid),  64'h00);
    ARESET = 1'b0;
    tick(); tick();
    chk("t5_no_cmp_after", 64'(cmp_valid), 64'h00);
    chk("t5_idle_after",   64'(busy),      64'h0);
    aggr_data_rdy = 1'b0; req_vld = 8'h09;
    tick();
    chk("t5_rr_reset", 64'(req_rdy), 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snoop_txn_sched.md
Name: snoop_txn_sched

Overview:
- Schedules ACE snoop transactions on behalf of up to NUM_MASTERS initiating masters and sequences the cache-line aggregator for each transaction.
- Round-robin arbitrates pending snoop requests and broadcasts the AC snoop to every master except the initiator.
- Collects CR responses into the aggregator's crresp_vld mask, waits for the aggregator's data_rdy / no_data verdict, then reports completion to the initiator.
- Clears the aggregator before the next transaction.

Parameters:
NUM_MASTERS, 8, number of ACE masters; the aggregator all-valid check requires 8
ADDR_W, 32, snoop address width
TIMEOUT_CYC, 256, cycles allowed in WAIT_AGGR before error completion (>=2)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
req_vld  in  NUM_MASTERS  per-master snoop request pending
req_addr  in  NUM_MASTERS*ADDR_W  per-master address; slice i = [i*ADDR_W +: ADDR_W]
req_snoop  in  NUM_MASTERS*4  per-master ACSNOOP code
req_rdy  out  NUM_MASTERS  one-cycle accept pulse to granted master
ac_valid  out  NUM_MASTERS  per-target snoop valid
ac_ready  in  NUM_MASTERS  per-target snoop ready
ac_addr  out  ADDR_W  latched snoop address, shared by all targets
ac_snoop  out  4  latched snoop code
cr_valid  in  NUM_MASTERS  per-target CR response valid
cr_ready  out  NUM_MASTERS  per-target CR accept
crresp_vld  out  NUM_MASTERS  collected-response mask to aggregator; initiator bit forced 1
aggr_clear  out  1  one-cycle pulse resetting the aggregator
aggr_data_rdy  in  1  aggregator data ready
aggr_no_data  in  1  aggregator found no line
cmp_valid  out  NUM_MASTERS  completion to initiator, held until cmp_ready
cmp_ready  in  NUM_MASTERS  completion accept
cmp_nodata  out  1  completion qualifier: no snooped data
cmp_err  out  1  completion qualifier: timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (ARESET high at a clock edge), all outputs 0:
  - state = IDLE, rr_ptr = 0, all masks/counters 0.
  - Reset overrides any in-progress transaction; no completion is issued for an aborted transaction.
- States: IDLE, SNOOP, WAIT_AGGR, COMPLETE, CLEAR.
- IDLE:
  - If req_vld != 0, grant the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - Latch init_id, ac_addr, ac_snoop; pulse req_rdy[init_id] for one cycle; go to SNOOP.
  - Next cycle ac_valid = all ones except bit init_id.
- SNOOP:
  - ac_valid[i] drops the cycle after ac_valid[i] & ac_ready[i] at an edge.
  - cr_ready[i] = 1 only when bit i's AC handshake has completed and its CR has not yet been collected.
  - A cr_valid arriving in the same cycle as its own AC handshake is not accepted (cr_ready still 0); it must be held.
  - cr_valid[i] & cr_ready[i] sets collected[i]; further cr_valid on that bit is ignored.
  - crresp_vld = collected | (1 << init_id), registered.
  - When collected covers all targets, go to WAIT_AGGR and clear the timeout counter.
- WAIT_AGGR:
  - Counter increments each cycle.
  - aggr_data_rdy → COMPLETE with nodata=0, err=0.
  - Else aggr_no_data → COMPLETE with nodata=1.
  - If both are high in the same cycle, data_rdy wins.
  - Counter reaching TIMEOUT_CYC-1 with neither high → COMPLETE with err=1.
- COMPLETE:
  - cmp_valid[init_id], cmp_nodata and cmp_err are held stable until cmp_ready[init_id].
  - Then go to CLEAR.
- CLEAR:
  - aggr_clear = 1 for exactly one cycle.
  - crresp_vld and collected are zeroed; rr_ptr = (init_id+1) mod NUM_MASTERS.
  - Return to IDLE. The earliest next grant is the cycle after CLEAR.
- Other rules:
  - Requests arriving while busy stay pending (req_vld is level); no queueing internally.
  - A requester dropping req_vld before grant is simply not granted.
  - NUM_MASTERS=1: no targets, so SNOOP exits immediately to WAIT_AGGR.

Test Plan:
- req_vld=8'h04, addr 0x1000, snoop 4'h1; all ac_ready/cr_valid=1 → req_rdy=8'h04 pulse; ac_valid=8'hFB; crresp_vld reaches 8'hFF; aggr_data_rdy → cmp_valid=8'h04, nodata=0, err=0; aggr_clear pulse; rr_ptr=3.
- req_vld=8'h81 with rr_ptr=3 → master 7 granted first; after its completion master 0 granted; rr_ptr ends at 1.
- Target 5 delays ac_ready 10 cycles and cr_valid 3 more → ac_valid[5] held 10 cycles; crresp_vld[5]=0 until cr handshake; no WAIT_AGGR before then.
- cr_valid[2] asserted in same cycle as ac_ready[2] and then held → cr_ready[2] low that cycle; accepted the following cycle.
- Neither aggr_data_rdy nor aggr_no_data in TIMEOUT_CYC=16 → cmp_err=1 after 16 WAIT_AGGR cycles; aggr_no_data alone → cmp_nodata=1; both high together → nodata=0.
- ARESET asserted mid-SNOOP → next cycle ac_valid=0, cr_ready=0, crresp_vld=0, busy=0, no cmp_valid; rr_ptr=0.
